// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2,
        HALT = 2'd3
    } stall_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Lock bundle ordered front (PC) to back (MEM/WB).
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } lock_vec_t;

    localparam lock_vec_t LOCK_NONE  = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
    localparam lock_vec_t LOCK_FRONT = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
    localparam lock_vec_t LOCK_ALL   = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID-stage read of a register an EX-stage load is about to write.
// Purely combinational, zero latency; no handshake.
module load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_num,
    input  logic [4:0] id_rs_num,
    input  logic [4:0] id_rt_num,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rs_match = (ex_rd_num == id_rs_num);
    assign rt_match = id_uses_rt && (ex_rd_num == id_rt_num);
    assign load_use = ex_mem_read && (ex_rd_num != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: buffer locks, load-use bubbles, cache-miss freeze, halt latch, perf counters.
// Locks are combinational from state (Mealy in RUN); state and counters update on the rising edge.
// Memory backpressure: mem_req held until mem_ready is sampled; the whole pipe is frozen meanwhile.
module pipeline_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             mem_access_mem,
    input  logic             cache_hit_mem,
    input  logic             mem_ready,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_num,
    input  logic [4:0]       id_rs_num,
    input  logic [4:0]       id_rt_num,
    input  logic             id_uses_rt,
    input  logic             halted_wb,
    output logic             pc_lock,
    output logic             lock_if_id,
    output logic             lock_id_ex,
    output logic             lock_ex_mem,
    output logic             lock_mem_wb,
    output logic             bubble_id_ex,
    output logic             mem_req,
    output logic             cache_fill,
    output logic             halted,
    output logic             miss_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
);

    localparam int               WD_W     = (MISS_TIMEOUT > 0) ? $clog2(MISS_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(MISS_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    stall_state_t    state;
    stall_state_t    state_nxt;
    lock_vec_t       locks;
    logic            miss;
    logic            load_use;
    logic            bubble;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_inc;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd_num   (ex_rd_num),
        .id_rs_num   (id_rs_num),
        .id_rt_num   (id_rt_num),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    assign miss = mem_access_mem && !cache_hit_mem;

    always_comb begin
        state_nxt  = state;
        locks      = LOCK_NONE;
        bubble     = 1'b0;
        mem_req    = 1'b0;
        cache_fill = 1'b0;
        case (state)
            RUN: begin
                // A miss freezes everything, so any coincident hazard is simply re-seen after the fill.
                if (miss) begin
                    locks     = LOCK_ALL;
                    state_nxt = MISS;
                end else if (load_use) begin
                    locks  = LOCK_FRONT;
                    bubble = 1'b1;
                end
            end
            MISS: begin
                locks   = LOCK_ALL;
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                locks      = LOCK_ALL;
                cache_fill = 1'b1;
                state_nxt  = RUN;
            end
            HALT: begin
                locks = LOCK_ALL;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (halted_wb) begin
            state_nxt = HALT;
        end
    end

    assign pc_lock      = locks.pc;
    assign lock_if_id   = locks.if_id;
    assign lock_id_ex   = locks.id_ex;
    assign lock_ex_mem  = locks.ex_mem;
    assign lock_mem_wb  = locks.mem_wb;
    assign bubble_id_ex = bubble;

    assign wd_inc = wd_cnt + WD_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state        <= RUN;
            halted       <= 1'b0;
            miss_timeout <= 1'b0;
            wd_cnt       <= '0;
            stall_cycles <= '0;
            bubble_count <= '0;
        end else begin
            state <= state_nxt;
            if (halted_wb) begin
                halted <= 1'b1;
            end

            // Watchdog counts consecutive MISS cycles and parks at the limit.
            if (state == MISS) begin
                if (wd_cnt != WD_LIMIT) begin
                    wd_cnt <= wd_inc;
                    if ((MISS_TIMEOUT != 0) && (wd_inc == WD_LIMIT)) begin
                        miss_timeout <= 1'b1;
                    end
                end
            end else begin
                wd_cnt <= '0;
            end

            if (locks.mem_wb && (state != HALT) && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (bubble && (bubble_count != CNT_MAX)) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a default instance plus a short-watchdog, 2-bit-counter instance.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b;
    logic       mem_access_mem;
    logic       cache_hit_mem;
    logic       mem_ready;
    logic       ex_mem_read;
    logic [4:0] ex_rd_num;
    logic [4:0] id_rs_num;
    logic [4:0] id_rt_num;
    logic       id_uses_rt;
    logic       halted_wb;

    logic        pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb;
    logic        bubble_id_ex, mem_req, cache_fill, halted, miss_timeout;
    logic [31:0] stall_cycles, bubble_count;

    logic       w_pc_lock, w_lock_if_id, w_lock_id_ex, w_lock_ex_mem, w_lock_mem_wb;
    logic       w_bubble_id_ex, w_mem_req, w_cache_fill, w_halted, w_miss_timeout;
    logic [1:0] w_stall_cycles, w_bubble_count;

    pipeline_stall_ctrl #(.CNT_W(32), .MISS_TIMEOUT(1023)) dut (
        .clk(clk), .rst_b(rst_b),
        .mem_access_mem(mem_access_mem), .cache_hit_mem(cache_hit_mem), .mem_ready(mem_ready),
        .ex_mem_read(ex_mem_read), .ex_rd_num(ex_rd_num), .id_rs_num(id_rs_num),
        .id_rt_num(id_rt_num), .id_uses_rt(id_uses_rt), .halted_wb(halted_wb),
        .pc_lock(pc_lock), .lock_if_id(lock_if_id), .lock_id_ex(lock_id_ex),
        .lock_ex_mem(lock_ex_mem), .lock_mem_wb(lock_mem_wb), .bubble_id_ex(bubble_id_ex),
        .mem_req(mem_req), .cache_fill(cache_fill), .halted(halted), .miss_timeout(miss_timeout),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );

    pipeline_stall_ctrl #(.CNT_W(2), .MISS_TIMEOUT(4)) dut_wd (
        .clk(clk), .rst_b(rst_b),
        .mem_access_mem(mem_access_mem), .cache_hit_mem(cache_hit_mem), .mem_ready(mem_ready),
        .ex_mem_read(ex_mem_read), .ex_rd_num(ex_rd_num), .id_rs_num(id_rs_num),
        .id_rt_num(id_rt_num), .id_uses_rt(id_uses_rt), .halted_wb(halted_wb),
        .pc_lock(w_pc_lock), .lock_if_id(w_lock_if_id), .lock_id_ex(w_lock_id_ex),
        .lock_ex_mem(w_lock_ex_mem), .lock_mem_wb(w_lock_mem_wb), .bubble_id_ex(w_bubble_id_ex),
        .mem_req(w_mem_req), .cache_fill(w_cache_fill), .halted(w_halted), .miss_timeout(w_miss_timeout),
        .stall_cycles(w_stall_cycles), .bubble_count(w_bubble_count)
    );

    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] FRONT = 5'b11000;
    localparam logic [4:0] NONE  = 5'b00000;

    typedef struct packed {
        logic [9:0] v;
        logic       wd_to;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    logic [9:0] obs_v;
    assign obs_v = {pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb,
                    bubble_id_ex, mem_req, cache_fill, halted, miss_timeout};

    // Expected vector: {locks[pc..mem_wb], bubble, mem_req, cache_fill, halted, miss_timeout}
    function automatic logic [9:0] ev(input logic [4:0] lk, input logic bub, input logic req,
                                      input logic fill, input logic hlt, input logic to);
        return {lk, bub, req, fill, hlt, to};
    endfunction

    // Push the expectation for the current cycle, compare at the falling edge, then advance one cycle.
    task automatic step(input string tag, input logic [9:0] v, input logic wd_to);
        exp_t  e;
        string t;
        e.v     = v;
        e.wd_to = wd_to;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (obs_v === e.v) else begin
            bad++;
            $error("FAIL %s outputs: observed=%b expected=%b", t, obs_v, e.v);
        end
        total++;
        assert (w_miss_timeout === e.wd_to) else begin
            bad++;
            $error("FAIL %s wd_timeout: observed=%b expected=%b", t, w_miss_timeout, e.wd_to);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic idle();
        mem_access_mem = 1'b0;
        cache_hit_mem  = 1'b1;
        mem_ready      = 1'b0;
        ex_mem_read    = 1'b0;
        ex_rd_num      = 5'd0;
        id_rs_num      = 5'd0;
        id_rt_num      = 5'd0;
        id_uses_rt     = 1'b0;
        halted_wb      = 1'b0;
    endtask

    initial begin
        idle();
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        step("reset", ev(NONE, 0, 0, 0, 0, 0), 1'b0);
        chk("reset_stall", stall_cycles, 0);
        chk("reset_bubble", bubble_count, 0);

        // Load-use on rs
        ex_mem_read = 1'b1; ex_rd_num = 5'd8; id_rs_num = 5'd8;
        step("lu_rs", ev(FRONT, 1, 0, 0, 0, 0), 1'b0);
        chk("lu_rs_bubble", bubble_count, 1);
        idle();
        step("lu_rs_after", ev(NONE, 0, 0, 0, 0, 0), 1'b0);

        // Load-use on rt, then rt ignored when not read
        ex_mem_read = 1'b1; ex_rd_num = 5'd9; id_rs_num = 5'd3; id_rt_num = 5'd9; id_uses_rt = 1'b1;
        step("lu_rt", ev(FRONT, 1, 0, 0, 0, 0), 1'b0);
        id_uses_rt = 1'b0;
        step("lu_rt_unused", ev(NONE, 0, 0, 0, 0, 0), 1'b0);

        // Load into $0 never stalls
        ex_rd_num = 5'd0; id_rs_num = 5'd0; id_rt_num = 5'd0; id_uses_rt = 1'b1;
        step("lu_zero", ev(NONE, 0, 0, 0, 0, 0), 1'b0);
        chk("lu_zero_bubble", bubble_count, 2);
        idle();

        // Miss, memory ready in the 5th mem_req cycle
        mem_access_mem = 1'b1; cache_hit_mem = 1'b0;
        step("miss_run", ev(ALL, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step("miss_wait", ev(ALL, 0, 1, 0, 0, 0), (i == 4) ? 1'b0 : 1'b0);
        end
        mem_ready = 1'b1;
        step("miss_ready", ev(ALL, 0, 1, 0, 0, 0), 1'b1);
        mem_ready = 1'b0;
        step("fill", ev(ALL, 0, 0, 1, 0, 0), 1'b1);
        cache_hit_mem = 1'b1;
        step("post_fill", ev(NONE, 0, 0, 0, 0, 0), 1'b1);
        chk("miss_stall", stall_cycles, 7);
        chk("wd_stall_sat", {30'd0, w_stall_cycles}, 3);
        mem_ready = 1'b1;
        step("ready_in_run", ev(NONE, 0, 0, 0, 0, 0), 1'b1);
        mem_ready = 1'b0;
        step("ready_in_run2", ev(NONE, 0, 0, 0, 0, 0), 1'b1);

        // Miss and load-use together: no bubble until after the fill
        cache_hit_mem = 1'b0; ex_mem_read = 1'b1; ex_rd_num = 5'd8; id_rs_num = 5'd8;
        step("mlu_run", ev(ALL, 0, 0, 0, 0, 0), 1'b1);
        mem_ready = 1'b1;
        step("mlu_miss", ev(ALL, 0, 1, 0, 0, 0), 1'b1);
        mem_ready = 1'b0;
        step("mlu_fill", ev(ALL, 0, 0, 1, 0, 0), 1'b1);
        cache_hit_mem = 1'b1;
        step("mlu_hazard", ev(FRONT, 1, 0, 0, 0, 0), 1'b1);
        chk("mlu_bubble", bubble_count, 3);
        chk("mlu_stall", stall_cycles, 10);
        idle();
        step("mlu_done", ev(NONE, 0, 0, 0, 0, 0), 1'b1);
        ex_mem_read = 1'b1; ex_rd_num = 5'd4; id_rs_num = 5'd4;
        step("lu_sat", ev(FRONT, 1, 0, 0, 0, 0), 1'b1);
        chk("bubble_4", bubble_count, 4);
        chk("wd_bubble_sat", {30'd0, w_bubble_count}, 3);
        idle();

        // Halt during MISS
        mem_access_mem = 1'b1; cache_hit_mem = 1'b0;
        step("h_run", ev(ALL, 0, 0, 0, 0, 0), 1'b1);
        step("h_miss1", ev(ALL, 0, 1, 0, 0, 0), 1'b1);
        halted_wb = 1'b1;
        step("h_miss2", ev(ALL, 0, 1, 0, 0, 0), 1'b1);
        halted_wb = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("halt", ev(ALL, 0, 0, 0, 1, 0), 1'b1);
        end
        chk("halt_stall", stall_cycles, 13);

        // Reset out of HALT, then watchdog with memory never ready
        mem_ready = 1'b0; rst_b = 1'b0;
        step("halt_rst", ev(ALL, 0, 0, 0, 1, 0), 1'b1);
        rst_b = 1'b1; idle();
        step("post_rst", ev(NONE, 0, 0, 0, 0, 0), 1'b0);
        chk("post_rst_stall", stall_cycles, 0);
        chk("post_rst_bubble", bubble_count, 0);
        mem_access_mem = 1'b1; cache_hit_mem = 1'b0;
        step("wd_run", ev(ALL, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step("wd_miss", ev(ALL, 0, 1, 0, 0, 0), 1'b0);
        end
        step("wd_tripped", ev(ALL, 0, 1, 0, 0, 0), 1'b1);
        rst_b = 1'b0;
        step("wd_rst", ev(ALL, 0, 1, 0, 0, 0), 1'b1);
        rst_b = 1'b1; idle();
        step("wd_post_rst", ev(NONE, 0, 0, 0, 0, 0), 1'b0);
        step("wd_no_fill", ev(NONE, 0, 0, 0, 0, 0), 1'b0);
        chk("wd_post_rst_stall", {30'd0, w_stall_cycles}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
